// File: rtl/gray_rx_pkg.sv
// Shared types and helpers for the Gray-code receive checker.
package gray_rx_pkg;

    // Lock FSM; encoding is visible on state_o
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_SLIP     = 2'd2
    } rx_state_t;

    // Relationship of a new sample to the previous one
    typedef enum logic [1:0] {
        CLS_HOLD = 2'd0,
        CLS_STEP = 2'd1,
        CLS_BAD  = 2'd2
    } step_cls_t;

    // Helpers work on a fixed maximum width; callers zero-extend in and truncate out
    localparam int unsigned GRAY_MAXW = 64;
    localparam int unsigned SAT_MAXW  = 32;

    // Prefix XOR from the MSB down: b[i] = b[i+1] ^ g[i]
    function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
        logic [GRAY_MAXW-1:0] b;
        b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
        for (int unsigned i = GRAY_MAXW - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

    // Adds inc to v and clamps at 2^w-1 (w < SAT_MAXW)
    function automatic logic [SAT_MAXW-1:0] sat_inc(input logic [SAT_MAXW-1:0] v,
                                                    input logic [1:0]          inc,
                                                    input int unsigned         w);
        logic [SAT_MAXW:0] sum;
        logic [SAT_MAXW:0] lim;
        sum = {1'b0, v} + {{(SAT_MAXW-1){1'b0}}, inc};
        lim = ({{SAT_MAXW{1'b0}}, 1'b1} << w) - {{SAT_MAXW{1'b0}}, 1'b1};
        return (sum > lim) ? lim[SAT_MAXW-1:0] : sum[SAT_MAXW-1:0];
    endfunction

endpackage

// File: rtl/gray2bin_stage.sv
// Registered Gray-to-binary conversion with valid pass-through.
// The combinational conversion is also exported so the caller can
// classify the sample in the same cycle it is registered.
module gray2bin_stage
    import gray_rx_pkg::*;
#(
    parameter int unsigned CBITS = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [CBITS-1:0] i_gray,
    output logic [CBITS-1:0] o_bin_d,
    output logic [CBITS-1:0] o_bin,
    output logic             o_valid
);

    // Combinational conversion of the staged Gray code
    always_comb begin
        o_bin_d = CBITS'(gray2bin(GRAY_MAXW'(i_gray)));
    end

    // Capture the binary value on valid; hold it otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            o_bin   <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_bin <= o_bin_d;
            end
        end
    end

endmodule

// File: rtl/gray_rx_checker.sv
// Consumer of the free-running Gray counter: converts to binary over two
// stages, checks hold/+1 continuity and the zero flag, tracks lock and
// keeps saturating wrap and error counters.
module gray_rx_checker
    import gray_rx_pkg::*;
#(
    parameter int unsigned CBITS    = 18,
    parameter int unsigned WBITS    = 8,
    parameter int unsigned RELOCK_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [CBITS-1:0] gray_in,
    input  logic             sig_in,
    output logic [CBITS-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_err,
    output logic             sig_err,
    output logic             locked,
    output logic [1:0]       state_o,
    output logic [WBITS-1:0] wrap_cnt,
    output logic [WBITS-1:0] err_cnt
);

    localparam int unsigned GW = $clog2(RELOCK_N + 1);

    logic             r_v1;
    logic [CBITS-1:0] r_g1;
    logic             r_s1;
    logic [CBITS-1:0] r_prev_bin;
    logic [GW-1:0]    r_good_cnt;
    rx_state_t        r_state;

    logic [CBITS-1:0] w_bin;
    logic [CBITS-1:0] w_prev_inc;
    logic [GW-1:0]    w_good_inc;
    step_cls_t        w_cls;
    rx_state_t        w_state_nxt;
    logic [GW-1:0]    w_good_nxt;
    logic             w_step_err;
    logic             w_sig_err;
    logic             w_wrap_inc;
    logic [1:0]       w_err_add;

    // Stage 1: capture the raw sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_g1 <= '0;
            r_s1 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_g1 <= gray_in;
                r_s1 <= sig_in;
            end
        end
    end

    // Stage 2 conversion; drives bin_out/bin_valid directly
    gray2bin_stage #(
        .CBITS (CBITS)
    ) u_stage2 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_v1),
        .i_gray  (r_g1),
        .o_bin_d (w_bin),
        .o_bin   (bin_out),
        .o_valid (bin_valid)
    );

    // Classify the staged sample against the previous value (mod 2^CBITS)
    always_comb begin
        w_prev_inc = r_prev_bin + CBITS'(1);
        if (w_bin == r_prev_bin) begin
            w_cls = CLS_HOLD;
        end else if (w_bin == w_prev_inc) begin
            w_cls = CLS_STEP;
        end else begin
            w_cls = CLS_BAD;
        end
    end

    // FSM state register with the relock step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_UNLOCKED;
            r_good_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
        end
    end

    // FSM next state; bubbles leave everything unchanged
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_good_inc  = r_good_cnt + GW'(1);
        if (r_v1) begin
            case (r_state)
                ST_UNLOCKED: begin
                    w_state_nxt = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (w_cls == CLS_BAD) begin
                        w_state_nxt = ST_SLIP;
                        w_good_nxt  = '0;
                    end
                end
                ST_SLIP: begin
                    case (w_cls)
                        CLS_STEP: begin
                            if (w_good_inc == GW'(RELOCK_N)) begin
                                w_state_nxt = ST_LOCKED;
                                w_good_nxt  = '0;
                            end else begin
                                w_good_nxt = w_good_inc;
                            end
                        end
                        CLS_BAD:  w_good_nxt = '0;
                        default:  w_good_nxt = r_good_cnt;
                    endcase
                end
                default: begin
                    w_state_nxt = ST_UNLOCKED;
                    w_good_nxt  = '0;
                end
            endcase
        end
    end

    // FSM outputs: error pulses and wrap event for the staged sample
    always_comb begin
        w_sig_err  = r_v1 && (r_s1 != (r_g1 == '0));
        w_step_err = r_v1 && (r_state != ST_UNLOCKED) && (w_cls == CLS_BAD);
        w_wrap_inc = r_v1 && (r_state == ST_LOCKED) && (w_cls == CLS_STEP) && (w_bin == '0);
        w_err_add  = {1'b0, w_step_err} + {1'b0, w_sig_err};
    end

    // Stage 2 registered status, history and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            step_err   <= 1'b0;
            sig_err    <= 1'b0;
            wrap_cnt   <= '0;
            err_cnt    <= '0;
            r_prev_bin <= '0;
        end else begin
            step_err <= w_step_err;
            sig_err  <= w_sig_err;
            if (r_v1) begin
                r_prev_bin <= w_bin;
            end
            if (w_wrap_inc) begin
                wrap_cnt <= WBITS'(sat_inc(SAT_MAXW'(wrap_cnt), 2'd1, WBITS));
            end
            err_cnt <= WBITS'(sat_inc(SAT_MAXW'(err_cnt), w_err_add, WBITS));
        end
    end

    always_comb begin
        locked  = (r_state == ST_LOCKED);
        state_o = r_state;
    end

endmodule

// File: tb/tb_gray_rx_checker.sv
// Bench for gray_rx_checker: directed scenarios plus random traffic,
// all checked cycle by cycle against a behavioural model.
module tb_gray_rx_checker;

    localparam int CB   = 4;
    localparam int WB   = 2;
    localparam int RN   = 4;
    localparam int CMAX = (1 << CB) - 1;
    localparam int WMAX = (1 << WB) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [CB-1:0] gray_in;
    logic          sig_in;
    logic [CB-1:0] bin_out;
    logic          bin_valid;
    logic          step_err;
    logic          sig_err;
    logic          locked;
    logic [1:0]    state_o;
    logic [WB-1:0] wrap_cnt;
    logic [WB-1:0] err_cnt;

    gray_rx_checker #(
        .CBITS    (CB),
        .WBITS    (WB),
        .RELOCK_N (RN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .gray_in   (gray_in),
        .sig_in    (sig_in),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .step_err  (step_err),
        .sig_err   (sig_err),
        .locked    (locked),
        .state_o   (state_o),
        .wrap_cnt  (wrap_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: state 0 unlocked / 1 locked / 2 slip, plus expected outputs
    int m_state, m_prev, m_good, m_wrap, m_err, m_bin;
    bit m_bv, m_se, m_ge;
    // Samples accepted by the model but not yet emerged (2-cycle latency)
    bit p_v, p_s;
    int p_g;
    int last_bin = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & CMAX;
    endfunction

    function automatic int from_gray(input int g);
        int b = 0;
        for (int k = 0; k < CB; k++) b ^= (g >> k);
        return b & CMAX;
    endfunction

    function automatic int sat(input int v);
        return (v > WMAX) ? WMAX : v;
    endfunction

    task automatic model_edge(input bit r, input bit v, input int g, input bit s);
        int  b;
        bit  hold, stp;
        if (r) begin
            m_state = 0; m_prev = 0; m_good = 0; m_wrap = 0; m_err = 0; m_bin = 0;
            m_bv = 0; m_se = 0; m_ge = 0;
            p_v = 0; p_g = 0; p_s = 0;
            return;
        end
        m_bv = 0; m_se = 0; m_ge = 0;
        if (p_v) begin
            b    = from_gray(p_g);
            m_bin = b;
            m_bv = 1;
            m_ge = (p_s != (p_g == 0));
            hold = (b == m_prev);
            stp  = (b == ((m_prev + 1) % (CMAX + 1)));
            if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 1) begin
                if (stp && b == 0) m_wrap = sat(m_wrap + 1);
                if (!hold && !stp) begin
                    m_se = 1; m_state = 2; m_good = 0;
                end
            end else begin
                if (stp) begin
                    m_good++;
                    if (m_good == RN) begin
                        m_state = 1; m_good = 0;
                    end
                end else if (!hold) begin
                    m_se = 1; m_good = 0;
                end
            end
            m_prev = b;
            m_err = sat(m_err + int'(m_se) + int'(m_ge));
        end
        p_v = v; p_g = g; p_s = s;
    endtask

    // One clock: drive, advance the model, sample 1 time unit after the edge
    task automatic tick(input bit r, input bit v, input int b, input bit flip);
        int g = to_gray(b & CMAX);
        bit s = (g == 0) ^ flip;
        rst      = r;
        in_valid = v;
        gray_in  = g[CB-1:0];
        sig_in   = s;
        @(posedge clk);
        model_edge(r, v, g, s);
        #1;
        chk("bin_valid", int'(bin_valid), int'(m_bv));
        chk("bin_out",   int'(bin_out),   m_bin);
        chk("step_err",  int'(step_err),  int'(m_se));
        chk("sig_err",   int'(sig_err),   int'(m_ge));
        chk("state_o",   int'(state_o),   m_state);
        chk("locked",    int'(locked),    int'(m_state == 1));
        chk("wrap_cnt",  int'(wrap_cnt),  m_wrap);
        chk("err_cnt",   int'(err_cnt),   m_err);
        if (r) last_bin = 0;
        else if (v) last_bin = b & CMAX;
    endtask

    task automatic feed(input int b);
        tick(1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 0, 1'b0);
        tick(1'b1, 1'b0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; gray_in = '0; sig_in = 1'b1;

        // Reset state
        do_reset();
        chk("rst_state", int'(state_o), 0);
        chk("rst_bin_valid", int'(bin_valid), 0);

        // Ascending run 0..4 with correct flag
        for (int i = 0; i <= 4; i++) feed(i);
        idle(2);
        chk("run_last_bin", int'(bin_out), 4);
        chk("run_locked", int'(locked), 1);
        chk("run_err", int'(err_cnt), 0);

        // Wrap through 15 -> 0
        do_reset();
        feed(13); feed(14); feed(15); feed(0); feed(1);
        idle(2);
        chk("wrap_once", int'(wrap_cnt), 1);
        chk("wrap_no_err", int'(err_cnt), 0);

        // Slip and relock, with a restart of the relock count
        do_reset();
        feed(5); feed(9); feed(10); feed(11); feed(3);
        idle(2);
        chk("slip_state", int'(state_o), 2);
        feed(4); feed(5); feed(6); feed(7);
        idle(2);
        chk("relock", int'(locked), 1);
        chk("slip_err", int'(err_cnt), 2);

        // Zero-flag errors on otherwise legal samples
        do_reset();
        tick(1'b0, 1'b1, 2, 1'b1);
        for (int i = 3; i <= 15; i++) feed(i);
        tick(1'b0, 1'b1, 0, 1'b1);
        idle(2);
        chk("sig_err_cnt", int'(err_cnt), 2);
        chk("sig_locked", int'(state_o), 1);

        // Saturation of err_cnt
        do_reset();
        feed(0); feed(8); feed(0); feed(8); feed(0); feed(8);
        idle(2);
        chk("err_sat", int'(err_cnt), WMAX);

        // Reset right behind a sample, then a fresh sample
        do_reset();
        feed(6);
        tick(1'b1, 1'b0, 0, 1'b0);
        idle(2);
        chk("flush_state", int'(state_o), 0);
        feed(11);
        idle(2);
        chk("post_rst_bin", int'(bin_out), 11);
        chk("post_rst_err", int'(err_cnt), 0);

        // Random traffic
        do_reset();
        for (int n = 0; n < 800; n++) begin
            int c, b;
            if ($urandom_range(99) < 2) begin
                tick(1'b1, 1'b0, 0, 1'b0);
            end else begin
                c = int'($urandom_range(9));
                if (c < 5)      b = (last_bin + 1) & CMAX;
                else if (c < 7) b = last_bin;
                else            b = int'($urandom_range(CMAX));
                tick(1'b0, ($urandom_range(99) < 75), b, ($urandom_range(19) == 0));
            end
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_rx_checker.md
Name: gray_rx_checker

Overview:
Consumer stage directly downstream of the free-running Gray counter. It samples the Gray code and its zero-indicator flag, then converts the code to binary through a 2-stage pipeline. It checks that every consecutive sample is a hold or a +1 step, tracks lock state, and counts wrap-arounds and errors. Its outputs feed the monitor/assertion layer and the software-visible status logic.

Parameters:
CBITS, 18, width of the Gray code input (matches the upstream counter width)
WBITS, 8, width of the saturating wrap and error counters
RELOCK_N, 4, consecutive good +1 steps needed to leave SLIP (must be >=1)

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous reset, active-high
in_valid  input  1  gray_in/sig_in are meaningful this cycle
gray_in  input  CBITS  Gray-coded count from upstream
sig_in  input  1  upstream flag, expected 1 iff gray_in == 0
bin_out  output  CBITS  binary value of the last accepted sample
bin_valid  output  1  bin_out updated this cycle (1-cycle pulse)
step_err  output  1  pulse: sample was neither hold nor +1 step
sig_err  output  1  pulse: sig_in disagrees with (gray_in == 0)
locked  output  1  FSM is in LOCKED
state_o  output  2  FSM state: 0 UNLOCKED, 1 LOCKED, 2 SLIP
wrap_cnt  output  WBITS  saturating count of max->0 transitions while LOCKED
err_cnt  output  WBITS  saturating count of step_err plus sig_err events

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - all outputs are 0; state is UNLOCKED.
  - internal prev_bin is 0 and the good-step counter is 0.
  - in-flight pipeline samples are discarded.
  - rst has priority over in_valid in the same cycle.
- Stage 1: when in_valid=1, register gray_in and sig_in and set v1=1; otherwise v1=0.
- Stage 2, conversion: b[CBITS-1] = g[CBITS-1]; b[i] = b[i+1] ^ g[i]. Registered into bin_out.
- Stage 2 outputs: bin_valid, step_err, sig_err and the counter updates all occur in the same cycle.
- Latency is exactly 2 cycles from in_valid to bin_valid. in_valid=0 produces a bubble with no check and no state change.
- Step classification against prev_bin, all arithmetic modulo 2^CBITS:
  - HOLD: b == prev_bin.
  - STEP: b == prev_bin+1.
  - BAD: anything else.
  - prev_bin is updated to b on every valid sample, including BAD samples.
- sig check: sig_err=1 when the staged sig differs from (staged g == 0). It is independent of step class and also applies in UNLOCKED.
- FSM:
  - UNLOCKED: first valid sample loads prev_bin with no step check; go to LOCKED.
  - LOCKED:
    - HOLD: stay.
    - STEP: stay; if prev_bin was all-ones and b == 0, wrap_cnt increments.
    - BAD: step_err=1; go to SLIP with good-step counter = 0.
  - SLIP:
    - STEP: counter+1; when it reaches RELOCK_N, go to LOCKED and clear the counter.
    - HOLD: counter unchanged.
    - BAD: step_err=1; counter = 0.
    - No wrap counting in SLIP.
- err_cnt adds step_err + sig_err, so +2 when both occur in the same sample. It saturates at 2^WBITS-1 and never wraps. wrap_cnt saturates the same way.
- Mid-operation rst returns the block to UNLOCKED. The first sample after reset is never flagged as a step error.

Decomposition:
- Package gray_rx_pkg:
  - state enum (UNLOCKED, LOCKED, SLIP) with a 2-bit encoding;
  - function gray2bin(CBITS);
  - saturating-increment function.
- One sub-module, gray2bin_stage: registered Gray-to-binary conversion with valid pass-through. It is instantiated as stage 2.

Test Plan:
- CBITS=4, rst then gray 0,1,3,2,6 (bin 0..4) with correct sig -> bin_out 0,1,2,3,4 each 2 cycles after input; locked=1 from the first bin_valid; no errors.
- CBITS=4, feed the full sequence bin 13,14,15,0,1 as Gray -> exactly one wrap_cnt increment, on the bin_valid where bin_out=0; err_cnt=0.
- Locked at bin 5, next sample bin 9 -> step_err pulse, state_o=2, err_cnt=1. Then bin 10,11,12,13 with RELOCK_N=4 -> locked=1 after the 4th step. A BAD sample at step 2 restarts the count.
- sig_in=1 with gray_in=3, then sig_in=0 with gray_in=0 -> two sig_err pulses, err_cnt=2, steps otherwise legal, state stays LOCKED.
- WBITS=2: inject 5 BAD samples -> err_cnt saturates at 3 and does not wrap to 0.
- Assert rst on the cycle after an in_valid -> no bin_valid emerges; state_o=0, all counters 0. The next sample (any value) loads without error.
